// File: rtl/skylark_hazard_ctrl_pkg.sv
// skylark_hcu_pkg: shared types and constants for the skylark hazard control unit.
// Revision 1.0
`default_nettype none

package skylark_hcu_pkg;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic w;
  } stage_ctl_t;

  localparam int REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/skylark_hazard_ctrl_wait_timer.sv
// hcu_wait_timer: saturating wait counter with a sticky timeout flag.
// Revision 1.0
`default_nettype none

module hcu_wait_timer #(
  parameter int WAIT_W       = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [WAIT_W-1:0] count,
  output logic              timeout
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);

  logic [WAIT_W-1:0] count_inc;
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr) begin
        count <= '0;
      end else if (en && count != WAIT_MAX) begin
        count <= count_inc;
      end
      // Sticky until reset; the pipeline keeps waiting after it sets.
      if (en && count != WAIT_MAX && count_inc == WAIT_MAX) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/skylark_hazard_ctrl.sv
// skylark_hazard_ctrl: stall/flush/forwarding authority for the 4-stage skylark core.
// Revision 1.0
`default_nettype none

module skylark_hazard_ctrl
  import skylark_hcu_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int ZERO_REG     = 1,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwe_w,
  input  logic              redirect_e,
  input  logic              mem_req_w,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              fwd_a_e,
  output logic              fwd_b_e,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  redirects
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);

  stage_ctl_t        stall;
  stage_ctl_t        flush;
  logic              mem_stall;
  logic              redirect_ok;
  logic [WAIT_W-1:0] wait_count;
  logic              wait_timeout;

  assign mem_stall   = mem_req_w & ~mem_ready;
  assign redirect_ok = redirect_e & ~mem_stall;

  function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    logic rd_is_zero;
    rd_is_zero = (ZERO_REG != 0) && (rd == REG_AW'(REG_ZERO));
    return we && (rd == rs) && !rd_is_zero;
  endfunction

  // Priority: reset, then memory stall, then redirect.
  always_comb begin
    stall = '0;
    flush = '0;
    if (reset) begin
      flush.d = 1'b1;
      flush.e = 1'b1;
      flush.w = 1'b1;
    end else if (mem_stall) begin
      stall = '1;
    end else if (redirect_ok) begin
      flush.d = 1'b1;
      flush.e = 1'b1;
    end
  end

  assign stall_f = stall.f;
  assign stall_d = stall.d;
  assign stall_e = stall.e;
  assign stall_w = stall.w;
  assign flush_d = flush.d;
  assign flush_e = flush.e;
  assign flush_w = flush.w | flush.f;

  assign fwd_a_e = fwd_hit(regwe_w, rd_w, rs1_e);
  assign fwd_b_e = fwd_hit(regwe_w, rd_w, rs2_e);

  hcu_wait_timer #(
    .WAIT_W       (WAIT_W),
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait (
    .clk     (clk),
    .reset   (reset),
    .en      (mem_stall),
    .clr     (~mem_stall),
    .count   (wait_count),
    .timeout (wait_timeout)
  );

  // The counter only sits at WAIT_MAX once the sticky flag is set, so this OR is equivalent.
  assign mem_timeout = wait_timeout | (wait_count == WAIT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (mem_stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirects <= '0;
    end else if (redirect_ok && redirects != '1) begin
      redirects <= redirects + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_skylark_hazard_ctrl.sv
// tb_skylark_hazard_ctrl: scoreboard bench for skylark_hazard_ctrl (default and CNT_W=4/ZERO_REG=0 builds).
// Revision 1.0
`default_nettype none

module tb_skylark_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic [4:0]  rs1_e = '0, rs2_e = '0, rd_w = '0;
  logic        regwe_w = 0, redirect_e = 0, mem_req_w = 0, mem_ready = 0;
  logic        stall_f, stall_d, stall_e, stall_w, flush_d, flush_e, flush_w;
  logic        fwd_a_e, fwd_b_e, mem_timeout;
  logic [31:0] stall_cycles, redirects;

  // Instance 2: ZERO_REG=0, CNT_W=4
  logic [4:0]  rs1_2 = '0, rs2_2 = '0, rd_2 = '0;
  logic        regwe_2 = 0, redirect_2 = 0, mem_req_2 = 0, mem_ready_2 = 0;
  logic        stall_f2, stall_d2, stall_e2, stall_w2, flush_d2, flush_e2, flush_w2;
  logic        fwd_a_2, fwd_b_2, mem_timeout_2;
  logic [3:0]  stall_cycles_2, redirects_2;

  skylark_hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_w(rd_w),
    .regwe_w(regwe_w), .redirect_e(redirect_e), .mem_req_w(mem_req_w), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .redirects(redirects)
  );

  skylark_hazard_ctrl #(.ZERO_REG(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .rs1_e(rs1_2), .rs2_e(rs2_2), .rd_w(rd_2),
    .regwe_w(regwe_2), .redirect_e(redirect_2), .mem_req_w(mem_req_2), .mem_ready(mem_ready_2),
    .stall_f(stall_f2), .stall_d(stall_d2), .stall_e(stall_e2), .stall_w(stall_w2),
    .flush_d(flush_d2), .flush_e(flush_e2), .flush_w(flush_w2),
    .fwd_a_e(fwd_a_2), .fwd_b_e(fwd_b_2), .mem_timeout(mem_timeout_2),
    .stall_cycles(stall_cycles_2), .redirects(redirects_2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  stall;
    logic [2:0]  flush;
    logic        fwd_a;
    logic        fwd_b;
    logic        to;
    logic [31:0] sc;
    logic [31:0] rd;
    logic [3:0]  wait_cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state (value before the coming edge)
  int          m_wait = 0;
  logic        m_to = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_rd = 0;

  task automatic step(input logic rq, input logic rdy, input logic redir, input logic we,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e, got;
    logic ms;
    mem_req_w = rq; mem_ready = rdy; redirect_e = redir;
    regwe_w = we; rd_w = rd; rs1_e = r1; rs2_e = r2;
    if (reset) begin m_wait = 0; m_to = 0; m_sc = 0; m_rd = 0; end
    ms = rq && !rdy;
    e.stall    = reset ? 4'h0 : (ms ? 4'hf : 4'h0);
    e.flush    = reset ? 3'b111 : ((!ms && redir) ? 3'b110 : 3'b000);
    e.fwd_a    = we && (rd == r1) && (rd != 0);
    e.fwd_b    = we && (rd == r2) && (rd != 0);
    e.to       = m_to;
    e.sc       = m_sc;
    e.rd       = m_rd;
    e.wait_cnt = 4'(m_wait);
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    chk("stall",        {stall_f, stall_d, stall_e, stall_w}, got.stall);
    chk("flush",        {flush_d, flush_e, flush_w}, got.flush);
    chk("fwd_a",        fwd_a_e, got.fwd_a);
    chk("fwd_b",        fwd_b_e, got.fwd_b);
    chk("mem_timeout",  mem_timeout, got.to);
    chk("stall_cycles", stall_cycles, got.sc);
    chk("redirects",    redirects, got.rd);
    chk("wait_count",   dut.u_wait.count, got.wait_cnt);
    if (!reset) begin
      if (ms) begin
        m_sc = m_sc + 1;
        if (m_wait < 15) begin
          m_wait = m_wait + 1;
          if (m_wait == 15) m_to = 1;
        end
      end else begin
        m_wait = 0;
        if (redir) m_rd = m_rd + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    reset = 1'b0;
    idle();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Reset asserted in the middle of a long memory wait
    repeat (5) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    repeat (2) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    reset = 1'b0;
    idle();

    // Forwarding, including the hardwired-zero register
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd6);
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    step(1, 0, 0, 1, 5'd9, 5'd3, 5'd9);
    step(0, 0, 0, 0, 5'd7, 5'd7, 5'd7);
    regwe_2 = 1; rd_2 = 5'd0; rs1_2 = 5'd3; rs2_2 = 5'd0;
    #1;
    chk("fwd_b_noz", fwd_b_2, 1'b1);
    chk("fwd_a_noz", fwd_a_2, 1'b0);
    regwe_2 = 0;

    // Short memory wait: three stall cycles then a ready
    do_reset();
    repeat (3) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle();
    chk("short_wait_sc", stall_cycles, 32'd3);
    chk("short_wait_to", mem_timeout, 1'b0);

    // Long memory wait past the timeout threshold
    do_reset();
    repeat (20) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle();
    chk("long_wait_sc", stall_cycles, 32'd20);
    chk("long_wait_to", mem_timeout, 1'b1);

    // Redirect deferred behind a memory stall
    do_reset();
    repeat (2) step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    idle();
    chk("deferred_redirects", redirects, 32'd1);

    // Redirect together with forwarding, no stall
    step(0, 0, 1, 1, 5'd4, 5'd4, 5'd4);
    idle();

    // Saturation of the 4-bit stall counter
    mem_req_2 = 1; mem_ready_2 = 0;
    repeat (14) @(negedge clk);
    #1;
    chk("sat_pre", stall_cycles_2, 4'd14);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("sat_hold", stall_cycles_2, 4'd15);
    end
    mem_req_2 = 0;
    @(negedge clk);
    #1;
    chk("sat_after", stall_cycles_2, 4'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
